// File: rtl/frame_defs_pkg.sv
// Shared definitions for the serial frame datapath: default frame geometry
// and the detector state encoding for the default sync pattern.
package frame_defs;

  localparam int DATA_W_DEF = 8;
  localparam int PAT_W_DEF  = 4;
  localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 4'b1101;

  // Detector state value equals the number of pattern bits currently matched.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } det_state_e;

  // Register width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_detector.sv
// Overlapping Moore sync-pattern detector. The state counts matched pattern
// bits; a mismatch falls back to the longest pattern prefix still matching.
module seq_detector
  import frame_defs::*;
#(
  parameter int                 PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0]   PATTERN = PATTERN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic match
);

  localparam int ST_W = cnt_width(PAT_W + 1);
  localparam logic [ST_W-1:0] ST_IDLE  = ST_W'(S0);
  localparam logic [ST_W-1:0] ST_MATCH = ST_W'(PAT_W);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_state_nxt;

  // Longest L such that the last L bits of (matched prefix, din) equal the
  // first L pattern bits. Pattern bit j (MSB first) is PATTERN[PAT_W-1-j].
  function automatic logic [ST_W-1:0] f_advance(input logic [ST_W-1:0] k,
                                                input logic            bit_in);
    logic [ST_W-1:0] best;
    logic            ok;
    int              idx;
    best = ST_IDLE;
    for (int l = 1; l <= PAT_W; l++) begin
      ok = (l <= int'(k) + 1);
      for (int j = 0; j < PAT_W; j++) begin
        if (ok && (j < l)) begin
          idx = int'(k) + 1 - l + j;
          if (idx < int'(k)) ok = (PATTERN[PAT_W-1-idx] == PATTERN[PAT_W-1-j]);
          else               ok = (bit_in == PATTERN[PAT_W-1-j]);
        end
      end
      if (ok) best = ST_W'(l);
    end
    return best;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the hold value is assigned first so no path leaves w_state_nxt
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (clr)     w_state_nxt = ST_IDLE;
    else if (en) w_state_nxt = f_advance(r_state, din);
  end

  assign match = (r_state == ST_MATCH);

endmodule

// File: rtl/serial_frame_dp2.sv
// Serial frame datapath: sync detector, payload shift register with up-counter,
// and a saturating down-counter. Strobes come from an external controller.
module serial_frame_dp2
  import frame_defs::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
  parameter int               DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serin,
  input  logic              en_det,
  input  logic              set_8,
  input  logic              en_cnt_8,
  input  logic              ld_down,
  input  logic              en_downcnt,
  output logic              out_det,
  output logic              out_cnt_8,
  output logic              out_downcnt,
  output logic [DATA_W-1:0] payload,
  output logic [DATA_W-1:0] down_val
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_payload;
  logic [DATA_W-1:0] r_down;
  logic              w_det;

  seq_detector #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_det (
    .clk   (clk),
    .rst   (rst),
    .clr   (set_8),
    .en    (en_det),
    .din   (serin),
    .match (w_det)
  );

  // Up-counter and payload shift share the set_8 > en_cnt_8 priority.
  always_ff @(posedge clk) begin
    if (rst || set_8) begin
      r_cnt     <= '0;
      r_payload <= '0;
    end else if (en_cnt_8) begin
      r_payload <= {r_payload[DATA_W-2:0], serin};
      r_cnt     <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  // Down-counter saturates at zero; a load always beats a decrement.
  always_ff @(posedge clk) begin
    if (rst)                            r_down <= '0;
    else if (ld_down)                   r_down <= r_payload;
    else if (en_downcnt && r_down != 0) r_down <= r_down - 1'b1;
  end

  assign out_det     = w_det;
  assign out_cnt_8   = (r_cnt == CNT_LAST);
  assign out_downcnt = (r_down == '0);
  assign payload     = r_payload;
  assign down_val    = r_down;

endmodule

// File: tb/tb_serial_frame_dp2.sv
// Self-checking bench for serial_frame_dp2: a behavioural model pushes the
// expected post-edge outputs to a scoreboard queue; each scenario pops and compares.
module tb_serial_frame_dp2;

  logic       clk = 1'b0;
  logic       rst, serin, en_det, set_8, en_cnt_8, ld_down, en_downcnt;
  logic       out_det, out_cnt_8, out_downcnt;
  logic [7:0] payload, down_val;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       det;
    logic       cnt8;
    logic       dz;
    logic [7:0] pay;
    logic [7:0] down;
  } exp_t;

  exp_t sb[$];

  // Model state: detector as a history of enabled bits, not as an FSM.
  logic [3:0] m_hist;
  int         m_hv;
  int         m_cnt;
  logic [7:0] m_pay, m_down;

  serial_frame_dp2 dut (
    .clk         (clk),
    .rst         (rst),
    .serin       (serin),
    .en_det      (en_det),
    .set_8       (set_8),
    .en_cnt_8    (en_cnt_8),
    .ld_down     (ld_down),
    .en_downcnt  (en_downcnt),
    .out_det     (out_det),
    .out_cnt_8   (out_cnt_8),
    .out_downcnt (out_downcnt),
    .payload     (payload),
    .down_val    (down_val)
  );

  always #5 clk = ~clk;

  // Drive one cycle of strobes, push the expected result, sample #1 after the edge.
  task automatic step(input logic r, input logic ed, input logic s8, input logic ec,
                      input logic ld, input logic edn, input logic sin);
    exp_t       e;
    logic [7:0] old_pay;
    rst = r; en_det = ed; set_8 = s8; en_cnt_8 = ec;
    ld_down = ld; en_downcnt = edn; serin = sin;
    if (r) begin
      m_hist = '0; m_hv = 0; m_cnt = 0; m_pay = '0; m_down = '0;
    end else begin
      old_pay = m_pay;
      if (s8) begin
        m_hist = '0; m_hv = 0;
      end else if (ed) begin
        m_hist = {m_hist[2:0], sin};
        if (m_hv < 4) m_hv++;
      end
      if (s8) begin
        m_cnt = 0; m_pay = '0;
      end else if (ec) begin
        m_pay = {m_pay[6:0], sin};
        m_cnt = (m_cnt == 7) ? 0 : m_cnt + 1;
      end
      if (ld) m_down = old_pay;
      else if (edn && m_down != 0) m_down = m_down - 8'd1;
    end
    e.det  = (m_hv == 4) && (m_hist == 4'b1101);
    e.cnt8 = (m_cnt == 7);
    e.dz   = (m_down == 8'd0);
    e.pay  = m_pay;
    e.down = m_down;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    step(1, 0, 0, 0, 0, 0, 0);
    void'(sb.pop_front());
    step(1, 1, 1, 1, 1, 1, 1);
    e = sb.pop_front();
    n_vec++; if (out_det !== e.det)    begin n_err++; $display("FAIL reset_det got %b exp %b", out_det, e.det); end
    n_vec++; if (out_cnt_8 !== e.cnt8) begin n_err++; $display("FAIL reset_cnt8 got %b exp %b", out_cnt_8, e.cnt8); end
    n_vec++; if (out_downcnt !== 1'b1) begin n_err++; $display("FAIL reset_downcnt got %b exp 1", out_downcnt); end
    n_vec++; if (payload !== 8'h00)    begin n_err++; $display("FAIL reset_payload got %h exp 00", payload); end
    n_vec++; if (down_val !== 8'h00)   begin n_err++; $display("FAIL reset_down got %h exp 00", down_val); end
  endtask

  task automatic test_detect();
    exp_t       e;
    logic [7:0] bits = 8'b01101101;
    logic [7:0] want = 8'b00001001;
    step(0, 0, 1, 0, 0, 0, 0);
    void'(sb.pop_front());
    for (int i = 7; i >= 0; i--) begin
      step(0, 1, 0, 0, 0, 0, bits[i]);
      e = sb.pop_front();
      n_vec++;
      if (out_det !== e.det || out_det !== want[i]) begin
        n_err++; $display("FAIL detect_bit%0d got %b exp %b", 7 - i, out_det, e.det);
      end
    end
    step(0, 0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    n_vec++; if (out_det !== 1'b1) begin n_err++; $display("FAIL detect_hold got %b exp 1", out_det); end
    step(0, 1, 1, 0, 0, 0, 1);
    e = sb.pop_front();
    n_vec++; if (out_det !== 1'b0) begin n_err++; $display("FAIL detect_clr got %b exp 0", out_det); end
  endtask

  task automatic load_payload(input logic [7:0] b);
    exp_t e;
    step(0, 0, 1, 0, 0, 0, 0);
    void'(sb.pop_front());
    for (int i = 7; i >= 0; i--) begin
      step(0, 0, 0, 1, 0, 0, b[i]);
      e = sb.pop_front();
      n_vec++;
      if (payload !== e.pay) begin n_err++; $display("FAIL shift_payload got %h exp %h", payload, e.pay); end
    end
  endtask

  task automatic test_capture();
    exp_t       e;
    logic [7:0] bits = 8'hA7;
    step(0, 0, 1, 0, 0, 0, 0);
    e = sb.pop_front();
    n_vec++; if (out_cnt_8 !== 1'b0) begin n_err++; $display("FAIL capture_set8 got %b exp 0", out_cnt_8); end
    for (int i = 7; i >= 0; i--) begin
      step(0, 0, 0, 1, 0, 0, bits[i]);
      e = sb.pop_front();
      n_vec++;
      if (out_cnt_8 !== e.cnt8 || out_cnt_8 !== (i == 1)) begin
        n_err++; $display("FAIL capture_cnt8_edge%0d got %b exp %b", 8 - i, out_cnt_8, e.cnt8);
      end
    end
    n_vec++; if (payload !== 8'hA7) begin n_err++; $display("FAIL capture_payload got %h exp a7", payload); end
  endtask

  task automatic test_load_count();
    exp_t e;
    load_payload(8'h03);
    step(0, 0, 0, 0, 1, 1, 0);
    e = sb.pop_front();
    n_vec++; if (down_val !== 8'd3) begin n_err++; $display("FAIL load_priority got %0d exp 3", down_val); end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      e = sb.pop_front();
      n_vec++;
      if (down_val !== e.down || out_downcnt !== e.dz) begin
        n_err++; $display("FAIL downcount_%0d got %0d/%b exp %0d/%b", i, down_val, out_downcnt, e.down, e.dz);
      end
    end
  endtask

  task automatic test_zero_payload();
    exp_t e;
    load_payload(8'h09);
    step(0, 0, 0, 0, 1, 0, 0);
    e = sb.pop_front();
    n_vec++; if (down_val !== 8'd9 || out_downcnt !== 1'b0) begin n_err++; $display("FAIL zero_preload got %0d/%b exp 9/0", down_val, out_downcnt); end
    step(0, 0, 1, 0, 0, 0, 0);
    void'(sb.pop_front());
    step(0, 0, 0, 0, 1, 1, 0);
    e = sb.pop_front();
    n_vec++; if (down_val !== e.down || out_downcnt !== 1'b1) begin n_err++; $display("FAIL zero_load got %0d/%b exp 0/1", down_val, out_downcnt); end
  endtask

  task automatic test_reset_midframe();
    exp_t       e;
    logic [4:0] bits = 5'b11011;
    step(0, 0, 1, 0, 0, 0, 0);
    void'(sb.pop_front());
    for (int i = 4; i >= 0; i--) begin
      step(0, (i > 0), 0, 1, 0, 0, bits[i]);
      void'(sb.pop_front());
    end
    step(0, 0, 0, 0, 1, 0, 0);
    e = sb.pop_front();
    n_vec++;
    if (out_det !== e.det || payload !== e.pay || down_val !== e.down) begin
      n_err++; $display("FAIL premid got %b/%h/%h exp %b/%h/%h", out_det, payload, down_val, e.det, e.pay, e.down);
    end
    step(1, 1, 0, 1, 1, 1, 1);
    e = sb.pop_front();
    n_vec++;
    if ({out_det, out_cnt_8, out_downcnt, payload, down_val} !== {1'b0, 1'b0, 1'b1, 8'h00, 8'h00}) begin
      n_err++; $display("FAIL midframe_reset got %b%b%b/%h/%h exp 001/00/00", out_det, out_cnt_8, out_downcnt, payload, down_val);
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), ($urandom_range(0, 9) == 0), 1'($urandom),
           ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom));
      e = sb.pop_front();
      n_vec++;
      if (out_det !== e.det || out_cnt_8 !== e.cnt8 || out_downcnt !== e.dz ||
          payload !== e.pay || down_val !== e.down) begin
        n_err++;
        $display("FAIL random_c%0d got %b%b%b/%h/%h exp %b%b%b/%h/%h", c, out_det, out_cnt_8,
                 out_downcnt, payload, down_val, e.det, e.cnt8, e.dz, e.pay, e.down);
      end
    end
  endtask

  // Bench-side controller: hunt 1101, capture 8'h05, load, count down to ready.
  task automatic test_full_frame();
    exp_t       e;
    logic [3:0] sync = 4'b1101;
    logic [7:0] data = 8'h05;
    int         cycles;
    step(1, 0, 0, 0, 0, 0, 0);
    void'(sb.pop_front());
    step(0, 0, 1, 0, 0, 0, 0);
    void'(sb.pop_front());
    for (int i = 3; i >= 0; i--) begin
      step(0, 1, 0, 0, 0, 0, sync[i]);
      void'(sb.pop_front());
    end
    n_vec++; if (out_det !== 1'b1) begin n_err++; $display("FAIL frame_sync got %b exp 1", out_det); end
    step(0, 0, 1, 0, 0, 0, 0);
    void'(sb.pop_front());
    for (int i = 7; i >= 0; i--) begin
      step(0, 0, 0, 1, 0, 0, data[i]);
      void'(sb.pop_front());
    end
    step(0, 0, 0, 0, 1, 0, 0);
    e = sb.pop_front();
    n_vec++; if (down_val !== 8'd5 || out_downcnt !== 1'b0) begin n_err++; $display("FAIL frame_load got %0d/%b exp 5/0", down_val, out_downcnt); end
    cycles = 0;
    while (out_downcnt !== 1'b1 && cycles < 20) begin
      step(0, 0, 0, 0, 0, 1, 0);
      e = sb.pop_front();
      cycles++;
      n_vec++;
      if (down_val !== e.down) begin n_err++; $display("FAIL frame_down got %0d exp %0d", down_val, e.down); end
    end
    n_vec++; if (cycles != 5) begin n_err++; $display("FAIL frame_ready_cycles got %0d exp 5", cycles); end
  endtask

  initial begin
    rst = 1'b0; serin = 1'b0; en_det = 1'b0; set_8 = 1'b0;
    en_cnt_8 = 1'b0; ld_down = 1'b0; en_downcnt = 1'b0;
    test_reset();
    test_detect();
    test_capture();
    test_load_count();
    test_zero_payload();
    test_reset_midframe();
    test_random();
    test_full_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
